// File: rtl/ram_arb_pkg.sv
// Shared constants for the fetch/data RAM arbiter: FSM states, grant encoding, strobe values.
// Also holds the partial-store test used by both the arbiter and the LSU.
package ram_arb_pkg;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam logic [3:0] WSTRB_FULL = 4'hF;

  function automatic logic is_partial(input logic [3:0] wstrb);
    return (wstrb != 4'h0) && (wstrb != WSTRB_FULL);
  endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational 4-lane byte merge: lane i takes new_i when wstrb_i[i] is set, else old_i.
// Zero latency, no handshake.
module ram_byte_merge (
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < 4; i++) begin
      if (wstrb_i[i]) merged_o[i*8 +: 8] = new_i[i*8 +: 8];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch and data ports; responses 1 cycle after accept (2 for partial stores).
// Backpressure via per-port ready in IDLE only; responses cannot be stalled.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [3:0]  d_req_wstrb,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic [31:0] ram_addr,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  logic [0:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        if_rsp_vld_q, if_rsp_vld_d;
  logic        d_rsp_vld_q, d_rsp_vld_d;
  logic        gnt_if, gnt_d;
  logic        en_c, we_c;
  logic [31:0] merged;

  ram_byte_merge u_merge (
    .old_i   (ram_dout),
    .new_i   (wdata_q),
    .wstrb_i (wstrb_q),
    .merged_o(merged)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    if_rsp_vld_d = 1'b0;
    d_rsp_vld_d  = 1'b0;
    gnt_if       = 1'b0;
    gnt_d        = 1'b0;
    en_c         = 1'b0;
    we_c         = 1'b0;
    ram_addr     = d_req_addr;
    ram_din      = d_req_wdata;

    if (state_q == IDLE) begin
      // On conflict, data wins unless round-robin says it went last.
      gnt_d  = d_req_valid && (!if_req_valid || (RR_ENABLE == 0) || (last_grant_q == GNT_IF));
      gnt_if = if_req_valid && !gnt_d;

      if (gnt_if) begin
        en_c         = 1'b1;
        ram_addr     = if_req_addr;
        if_rsp_vld_d = 1'b1;
        last_grant_d = GNT_IF;
      end else if (gnt_d) begin
        last_grant_d = GNT_D;
        if (!d_req_we) begin
          en_c        = 1'b1;
          d_rsp_vld_d = 1'b1;
        end else if (d_req_wstrb == WSTRB_FULL) begin
          en_c        = 1'b1;
          we_c        = 1'b1;
          d_rsp_vld_d = 1'b1;
        end else if (!is_partial(d_req_wstrb)) begin
          d_rsp_vld_d = 1'b1;
        end else begin
          en_c    = 1'b1;
          addr_d  = d_req_addr;
          wdata_d = d_req_wdata;
          wstrb_d = d_req_wstrb;
          state_d = RMW_WR;
        end
      end
    end else begin
      // Old word arrives from the read issued last cycle; write back the merge.
      en_c        = 1'b1;
      we_c        = 1'b1;
      ram_addr    = addr_q;
      ram_din     = merged;
      d_rsp_vld_d = 1'b1;
      state_d     = IDLE;
    end
  end

  assign if_req_ready = rst_n && gnt_if;
  assign d_req_ready  = rst_n && gnt_d;
  assign ram_en       = rst_n && en_c;
  assign ram_we       = rst_n && we_c;
  assign if_rsp_valid = if_rsp_vld_q;
  assign d_rsp_valid  = d_rsp_vld_q;
  assign if_rsp_data  = ram_dout;
  assign d_rsp_data   = ram_dout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IF;
      if_rsp_vld_q <= 1'b0;
      d_rsp_vld_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if_rsp_vld_q <= if_rsp_vld_d;
      d_rsp_vld_q  <= d_rsp_vld_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Two arbiters (round-robin and fixed priority) driven side by side against a word-level memory model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        if_req_valid [2];
  logic        if_req_ready [2];
  logic [31:0] if_req_addr  [2];
  logic        if_rsp_valid [2];
  logic [31:0] if_rsp_data  [2];
  logic        d_req_valid  [2];
  logic        d_req_ready  [2];
  logic [31:0] d_req_addr   [2];
  logic        d_req_we     [2];
  logic [3:0]  d_req_wstrb  [2];
  logic [31:0] d_req_wdata  [2];
  logic        d_rsp_valid  [2];
  logic [31:0] d_rsp_data   [2];
  logic [31:0] ram_addr     [2];
  logic        ram_en       [2];
  logic        ram_we       [2];
  logic [31:0] ram_din      [2];
  logic [31:0] ram_dout     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_arbiter #(.RR_ENABLE((g == 0) ? 1 : 0)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_req_valid(if_req_valid[g]),
      .if_req_ready(if_req_ready[g]),
      .if_req_addr (if_req_addr[g]),
      .if_rsp_valid(if_rsp_valid[g]),
      .if_rsp_data (if_rsp_data[g]),
      .d_req_valid (d_req_valid[g]),
      .d_req_ready (d_req_ready[g]),
      .d_req_addr  (d_req_addr[g]),
      .d_req_we    (d_req_we[g]),
      .d_req_wstrb (d_req_wstrb[g]),
      .d_req_wdata (d_req_wdata[g]),
      .d_rsp_valid (d_rsp_valid[g]),
      .d_rsp_data  (d_rsp_data[g]),
      .ram_addr    (ram_addr[g]),
      .ram_en      (ram_en[g]),
      .ram_we      (ram_we[g]),
      .ram_din     (ram_din[g]),
      .ram_dout    (ram_dout[g])
    );
  end

  // Single-port RAM with registered read; dout only moves on read cycles.
  logic [31:0] mem [2][256];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_en[k]) begin
        if (ram_we[k]) mem[k][ram_addr[k][9:2]] <= ram_din[k];
        else           ram_dout[k] <= mem[k][ram_addr[k][9:2]];
      end
    end
  end

  typedef struct {
    int          due;
    bit          has_data;
    logic [31:0] data;
  } exp_t;

  exp_t        q [4][$];
  logic [31:0] ref_mem [2][256];
  bit          m_busy [2];
  bit          m_last_d [2];
  int          m_rmw_idx [2];
  logic [31:0] m_rmw_addr [2];
  logic [31:0] m_rmw_val [2];
  logic [31:0] m_rmw_old [2];
  bit          acc_if [2];
  bit          acc_d [2];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic push(input int qi, input int due, input bit has_data, input logic [31:0] data);
    exp_t e;
    e.due = due;
    e.has_data = has_data;
    e.data = data;
    q[qi].push_back(e);
  endtask

  // Reference model: decides grants and RAM activity from the arbitration rules.
  task automatic eval(input int k);
    bit xi, xd, xen, xwe;
    logic [31:0] xaddr, xdin, nv;
    int idx;
    xi = 0; xd = 0; xen = 0; xwe = 0; xaddr = '0; xdin = '0;
    if (!rst_n) begin
      if (m_busy[k]) ref_mem[k][m_rmw_idx[k]] = m_rmw_old[k];
      m_busy[k] = 0;
      m_last_d[k] = 0;
      for (int p = 0; p < 2; p++)
        while (q[k*2+p].size() > 0 && q[k*2+p][$].due > cyc) void'(q[k*2+p].pop_back());
    end else if (m_busy[k]) begin
      xen = 1; xwe = 1; xaddr = m_rmw_addr[k]; xdin = m_rmw_val[k];
      m_busy[k] = 0;
    end else begin
      xd = d_req_valid[k] && (!if_req_valid[k] || (k != 0) || !m_last_d[k]);
      xi = if_req_valid[k] && !xd;
      if (xi) begin
        idx = int'(if_req_addr[k][9:2]);
        xen = 1; xaddr = if_req_addr[k];
        push(k*2, cyc + 1, 1, ref_mem[k][idx]);
        m_last_d[k] = 0;
      end
      if (xd) begin
        idx = int'(d_req_addr[k][9:2]);
        xaddr = d_req_addr[k];
        m_last_d[k] = 1;
        if (!d_req_we[k]) begin
          xen = 1;
          push(k*2+1, cyc + 1, 1, ref_mem[k][idx]);
        end else if (d_req_wstrb[k] == 4'hF) begin
          xen = 1; xwe = 1; xdin = d_req_wdata[k];
          ref_mem[k][idx] = d_req_wdata[k];
          push(k*2+1, cyc + 1, 0, '0);
        end else if (d_req_wstrb[k] == 4'h0) begin
          push(k*2+1, cyc + 1, 0, '0);
        end else begin
          xen = 1;
          nv = ref_mem[k][idx];
          for (int b = 0; b < 4; b++)
            if (d_req_wstrb[k][b]) nv[b*8 +: 8] = d_req_wdata[k][b*8 +: 8];
          m_rmw_old[k] = ref_mem[k][idx];
          ref_mem[k][idx] = nv;
          m_rmw_val[k] = nv; m_rmw_addr[k] = d_req_addr[k]; m_rmw_idx[k] = idx;
          m_busy[k] = 1;
          push(k*2+1, cyc + 2, 0, '0);
        end
      end
    end
    chk("if_req_ready", k, {31'b0, if_req_ready[k]}, {31'b0, xi});
    chk("d_req_ready", k, {31'b0, d_req_ready[k]}, {31'b0, xd});
    chk("ram_en", k, {31'b0, ram_en[k]}, {31'b0, xen});
    chk("ram_we", k, {31'b0, ram_we[k]}, {31'b0, xwe});
    if (xen) chk("ram_word_addr", k, {2'b0, ram_addr[k][31:2]}, {2'b0, xaddr[31:2]});
    if (xwe) chk("ram_din", k, ram_din[k], xdin);
    acc_if[k] = (if_req_ready[k] === 1'b1);
    acc_d[k]  = (d_req_ready[k] === 1'b1);
  endtask

  task automatic mon(input int k, input int p, input logic v, input logic [31:0] data);
    exp_t e;
    int qi;
    qi = k*2 + p;
    if (v === 1'b1) begin
      n_chk++;
      if (q[qi].size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp dut%0d port%0d cycle %0d: got valid expected none", k, p, cyc);
      end else begin
        e = q[qi].pop_front();
        if (e.due != cyc) begin
          n_fail++;
          $display("FAIL rsp_timing dut%0d port%0d: got cycle %0d expected %0d", k, p, cyc, e.due);
        end else if (e.has_data && data !== e.data) begin
          n_fail++;
          $display("FAIL rsp_data dut%0d port%0d cycle %0d: got %h expected %h", k, p, cyc, data, e.data);
        end
      end
    end else if (q[qi].size() > 0 && q[qi][0].due <= cyc) begin
      n_chk++;
      n_fail++;
      e = q[qi].pop_front();
      $display("FAIL missing_rsp dut%0d port%0d: got none at cycle %0d expected at %0d", k, p, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon(k, 0, if_rsp_valid[k], if_rsp_data[k]);
      mon(k, 1, d_rsp_valid[k], d_rsp_data[k]);
    end
  end

  task automatic pre();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (acc_if[k]) if_req_valid[k] = 1'b0;
      if (acc_d[k])  d_req_valid[k]  = 1'b0;
      acc_if[k] = 0;
      acc_d[k]  = 0;
    end
  endtask

  task automatic post();
    @(negedge clk);
    for (int k = 0; k < 2; k++) eval(k);
  endtask

  task automatic new_if(input int k, input logic [31:0] a);
    if_req_valid[k] = 1'b1;
    if_req_addr[k]  = a;
  endtask

  task automatic new_d(input int k, input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
    d_req_valid[k] = 1'b1;
    d_req_we[k]    = we;
    d_req_addr[k]  = a;
    d_req_wstrb[k] = s;
    d_req_wdata[k] = wd;
  endtask

  function automatic logic [31:0] rand_addr(input int lo, input int hi);
    return (32'($urandom_range(hi, lo)) << 2) | 32'($urandom_range(3, 0));
  endfunction

  task automatic gen_random(input int k);
    int r;
    if (!if_req_valid[k] && $urandom_range(99, 0) < 60) new_if(k, rand_addr(0, 63));
    if (!d_req_valid[k] && $urandom_range(99, 0) < 60) begin
      r = $urandom_range(9, 0);
      if (r < 4)       new_d(k, 1'b0, rand_addr(0, 63), 4'($urandom), $urandom);
      else if (r < 6)  new_d(k, 1'b1, rand_addr(0, 63), 4'hF, $urandom);
      else if (r == 6) new_d(k, 1'b1, rand_addr(0, 63), 4'h0, $urandom);
      else             new_d(k, 1'b1, rand_addr(0, 63), 4'($urandom_range(14, 1)), $urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      pre();
      post();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    for (int k = 0; k < 2; k++) begin
      if_req_valid[k] = 0; if_req_addr[k] = '0;
      d_req_valid[k] = 0; d_req_addr[k] = '0; d_req_we[k] = 0;
      d_req_wstrb[k] = '0; d_req_wdata[k] = '0;
      m_busy[k] = 0; m_last_d[k] = 0; acc_if[k] = 0; acc_d[k] = 0;
      for (int i = 0; i < 256; i++) begin
        v = $urandom;
        mem[k][i] = v;
        ref_mem[k][i] = v;
      end
      mem[k][16] = 32'h11223344;
      ref_mem[k][16] = 32'h11223344;
    end

    // Reset state, with requests pending so forced-low readies are visible.
    pre();
    for (int k = 0; k < 2; k++) begin
      new_if(k, 32'h40);
      new_d(k, 1'b0, 32'h44, 4'h0, '0);
    end
    post();
    idle(2);
    pre();
    for (int k = 0; k < 2; k++) begin
      if_req_valid[k] = 0;
      d_req_valid[k] = 0;
    end
    rst_n = 1'b1;
    post();

    // Lone fetch of the preloaded word.
    pre();
    for (int k = 0; k < 2; k++) new_if(k, 32'h40);
    post();
    idle(3);

    // Full-word store then read back.
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b1, 32'h80, 4'hF, 32'hDEADBEEF);
    post();
    idle(2);
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b0, 32'h80, 4'h0, '0);
    post();
    idle(2);

    // Partial store with a fetch arriving during the merge cycle.
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b1, 32'h80, 4'b0010, 32'h0000AA00);
    post();
    pre();
    for (int k = 0; k < 2; k++) new_if(k, 32'h40);
    post();
    idle(3);
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b0, 32'h80, 4'h0, '0);
    post();
    idle(2);

    // Empty strobe: acknowledged without touching the RAM.
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b1, 32'h80, 4'h0, 32'hFFFFFFFF);
    post();
    idle(2);
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b0, 32'h80, 4'h0, '0);
    post();
    idle(2);

    // Both ports reading every cycle.
    repeat (12) begin
      pre();
      for (int k = 0; k < 2; k++) begin
        if (!if_req_valid[k]) new_if(k, rand_addr(0, 31));
        if (!d_req_valid[k])  new_d(k, 1'b0, rand_addr(32, 63), 4'h0, '0);
      end
      post();
    end
    idle(6);

    repeat (1500) begin
      pre();
      for (int k = 0; k < 2; k++) gen_random(k);
      post();
    end
    idle(8);

    // Reset landing on the merge cycle of a partial store.
    pre();
    for (int k = 0; k < 2; k++) new_d(k, 1'b1, 32'h80, 4'b0100, 32'h00550000);
    post();
    pre();
    rst_n = 1'b0;
    post();
    pre();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      new_if(k, 32'h40);
      new_d(k, 1'b0, 32'h80, 4'h0, '0);
    end
    post();
    idle(6);

    for (int k = 0; k < 2; k++) begin
      chk("if_queue_drained", k, 32'(q[k*2].size()), 32'd0);
      chk("d_queue_drained", k, 32'(q[k*2+1].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
